// File: rtl/nn_pkg.sv
// Shared types and width helpers for the sequential neural-layer block.
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_IDENT = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_STEP  = 2'd2
  } act_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } nn_state_t;

  // Accumulator wide enough that bias plus every product can never overflow.
  function automatic int acc_width(input int data_w, input int weight_w, input int n_in);
    return data_w + weight_w + $clog2(n_in) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_activation.sv
// Combinational activation: saturating identity, ReLU, or step on a wide accumulator.
module nn_activation
  import nn_pkg::*;
#(
  parameter int ACC_W  = 18,
  parameter int DATA_W = 8
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  act_mode_t                act_mode,
  output logic        [DATA_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic        [DATA_W-1:0] ONE    = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] sat_val;
  logic              acc_neg;
  logic              acc_pos;

  always_comb begin
    acc_neg = acc[ACC_W-1];
    acc_pos = !acc[ACC_W-1] && (|acc);
    if (acc > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (acc < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_val = acc[DATA_W-1:0];
    end
  end

  // The reserved encoding falls through to identity.
  always_comb begin
    result = sat_val;
    case (act_mode)
      ACT_RELU: result = acc_neg ? '0 : sat_val;
      ACT_STEP: result = acc_pos ? ONE : '0;
      default:  result = sat_val;
    endcase
  end

endmodule

// File: rtl/nn_layer_seq.sv
// Sequential fully-connected layer: one MAC per cycle, neuron outer / input inner.
// state | meaning: IDLE wait for vector | MAC accumulate | DONE hold result for consumer
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int N_OUT    = 3,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int BIAS_W   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_IN*DATA_W-1:0]           in_data,
  input  logic [N_OUT*N_IN*WEIGHT_W-1:0]   weights,
  input  logic [N_OUT*BIAS_W-1:0]          biases,
  input  logic [1:0]                       act_mode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_OUT*DATA_W-1:0]          out_data
);

  localparam int ACC_W = acc_width(DATA_W, WEIGHT_W, N_IN);
  localparam int I_W   = cnt_width(N_IN);
  localparam int J_W   = cnt_width(N_OUT);
  localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

  nn_state_t                  state_q, state_d;
  logic [N_IN*DATA_W-1:0]     in_q, in_d;
  act_mode_t                  mode_q, mode_d;
  logic [I_W-1:0]             i_q, i_d;
  logic [J_W-1:0]             j_q, j_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [N_OUT*DATA_W-1:0]    out_q, out_d;

  logic signed [DATA_W-1:0]   x_sel;
  logic signed [WEIGHT_W-1:0] w_sel;
  logic signed [BIAS_W-1:0]   b_sel;
  logic signed [ACC_W-1:0]    prod;
  logic signed [ACC_W-1:0]    acc_base;
  logic signed [ACC_W-1:0]    acc_sum;
  logic [DATA_W-1:0]          act_out;
  logic                       accept;
  logic                       last_in;
  logic                       last_mac;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      mode_q  <= ACT_IDENT;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    accept   = (state_q == ST_IDLE) && in_valid;
    last_in  = (i_q == I_LAST);
    last_mac = last_in && (j_q == J_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_MAC;
      ST_MAC:  if (last_mac) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    out_data  = out_q;
  end

  // Weights and biases are read live; the source holds them until out_valid.
  always_comb begin
    x_sel    = in_q[int'(i_q)*DATA_W +: DATA_W];
    w_sel    = weights[(int'(j_q)*N_IN + int'(i_q))*WEIGHT_W +: WEIGHT_W];
    b_sel    = biases[int'(j_q)*BIAS_W +: BIAS_W];
    prod     = ACC_W'(x_sel) * ACC_W'(w_sel);
    acc_base = (i_q == '0) ? ACC_W'(b_sel) : acc_q;
    acc_sum  = acc_base + prod;
  end

  nn_activation #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_act (
    .acc      (acc_sum),
    .act_mode (mode_q),
    .result   (act_out)
  );

  always_comb begin
    in_d   = in_q;
    mode_d = mode_q;
    i_d    = i_q;
    j_d    = j_q;
    acc_d  = acc_q;
    out_d  = out_q;
    if (accept) begin
      in_d   = in_data;
      mode_d = act_mode_t'(act_mode);
      i_d    = '0;
      j_d    = '0;
    end else if (state_q == ST_MAC) begin
      acc_d = acc_sum;
      if (last_in) begin
        i_d = '0;
        j_d = (j_q == J_LAST) ? '0 : j_q + 1'b1;
        out_d[int'(j_q)*DATA_W +: DATA_W] = act_out;
      end else begin
        i_d = i_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench for nn_layer_seq with a cycle-level behavioural model and literal pins.
module tb_nn_layer_seq;

  localparam int LAT = 7;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [47:0] weights;
  logic [47:0] biases;
  logic [1:0]  act_mode;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bit          m_busy = 0;
  int          m_cnt  = 0;
  logic [23:0] m_exp  = '0;
  int          acc_cyc_q[$];
  logic [23:0] got_q[$];

  nn_layer_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .weights   (weights),
    .biases    (biases),
    .act_mode  (act_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_vec(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %06h want %06h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  function automatic logic [23:0] pack3(input int s0, input int s1, input int s2);
    return {8'(s2), 8'(s1), 8'(s0)};
  endfunction

  // Plain arithmetic reference: y_j = act(b_j + sum_i x_i*w_ji).
  function automatic logic [23:0] model_layer(input logic [15:0] x, input logic [47:0] w,
                                              input logic [47:0] b, input logic [1:0] m);
    logic [23:0] r;
    int acc, xv, wv, y;
    r = '0;
    for (int j = 0; j < 3; j++) begin
      acc = int'($signed(b[j*16 +: 16]));
      for (int i = 0; i < 2; i++) begin
        xv = int'($signed(x[i*8 +: 8]));
        wv = int'($signed(w[(j*2+i)*8 +: 8]));
        acc += xv * wv;
      end
      y = (acc > 127) ? 127 : (acc < -128) ? -128 : acc;
      if (m == 2'd1 && acc < 0) y = 0;
      if (m == 2'd2) y = (acc > 0) ? 1 : 0;
      r[j*8 +: 8] = 8'(y);
    end
    return r;
  endfunction

  task automatic set_vec(input int x0, input int x1, input int w00, input int w01,
                         input int w10, input int w11, input int w20, input int w21,
                         input int b0, input int b1, input int b2, input logic [1:0] m);
    in_data  = {8'(x1), 8'(x0)};
    weights  = {8'(w21), 8'(w20), 8'(w11), 8'(w10), 8'(w01), 8'(w00)};
    biases   = {16'(b2), 16'(b1), 16'(b0)};
    act_mode = m;
  endtask

  // Single compare process: model tracks handshakes and timing from accept count.
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_cnt  = 0;
    end else begin
      check_bit("in_ready", in_ready, !m_busy);
      check_bit("out_valid", out_valid, m_busy && m_cnt >= LAT);
      if (m_busy && m_cnt >= LAT) check_vec("out_data", out_data, m_exp);
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1;
          m_cnt  = 1;
          m_exp  = model_layer(in_data, weights, biases, act_mode);
          acc_cyc_q.push_back(cyc);
        end
      end else if (m_cnt >= LAT) begin
        if (out_ready) m_busy = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic do_vec(input string tag, input logic [23:0] exp, input int stall);
    int lat;
    bit ok;
    @(posedge clk); #1;
    in_valid  = 1;
    out_ready = (stall == 0);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check_bit({tag, "_accept"}, ok, 1'b1);
    @(posedge clk); #1;
    in_valid = 0;
    in_data  = 16'hA5C3;
    act_mode = ~act_mode;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    check_int({tag, "_latency"}, lat, LAT);
    check_vec({tag, "_result"}, out_data, exp);
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check_bit({tag, "_hold_valid"}, out_valid, 1'b1);
        check_vec({tag, "_hold_data"}, out_data, exp);
        check_bit({tag, "_hold_busy"}, in_ready, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    check_bit({tag, "_idle_ready"}, in_ready, 1'b1);
    check_bit({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    int base_a, base_g;
    bit ok;
    logic [23:0] tp_exp[3];
    rst = 1; in_valid = 0; out_ready = 0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);

    set_vec(3, -2, 2, 1, -4, 1, 0, 0, 5, 0, 0, 2'd0);
    check_vec("model_v1", model_layer(in_data, weights, biases, act_mode), pack3(9, -14, 0));
    set_vec(3, -2, 2, 1, -4, 1, 0, 0, 5, 20, 0, 2'd2);
    check_vec("model_step", model_layer(in_data, weights, biases, act_mode), pack3(1, 1, 0));
    set_vec(127, 127, -128, -128, 1, -1, 127, 127, 0, 0, 0, 2'd0);
    check_vec("model_sat", model_layer(in_data, weights, biases, act_mode), pack3(-128, 0, 127));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_vec("rst_out_data", out_data, 24'h0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_bit("rel_in_ready", in_ready, 1'b1);
    check_vec("rel_out_data", out_data, 24'h0);

    set_vec(3, -2, 2, 1, -4, 1, 0, 0, 5, 0, 0, 2'd0);
    do_vec("ident", pack3(9, -14, 0), 0);
    set_vec(3, -2, 2, 1, -4, 1, 0, 0, 5, 0, 0, 2'd1);
    do_vec("relu", pack3(9, 0, 0), 0);
    set_vec(3, -2, 2, 1, -4, 1, 0, 0, 5, 0, 0, 2'd2);
    do_vec("step", pack3(1, 0, 0), 0);
    set_vec(3, -2, 2, 1, -4, 1, 0, 0, 5, 20, 0, 2'd2);
    do_vec("step_b20", pack3(1, 1, 0), 0);
    set_vec(127, 127, -128, -128, 1, -1, 127, 127, 0, 0, 0, 2'd0);
    do_vec("sat_stall", pack3(-128, 0, 127), 4);
    set_vec(127, 127, 127, 127, 0, 0, -128, -128, -32768, -1, 0, 2'd3);
    do_vec("reserved", pack3(-128, -1, -128), 0);
    set_vec(127, 127, 127, 127, -1, 0, 0, 1, 0, 0, -127, 2'd1);
    do_vec("relu_sat", pack3(127, 0, 0), 0);

    // Abort a transaction with reset three cycles after acceptance.
    set_vec(3, -2, 2, 1, -4, 1, 0, 0, 5, 0, 0, 2'd0);
    @(posedge clk); #1;
    in_valid = 1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check_bit("abort_accept", ok, 1'b1);
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_vec("abort_out_data", out_data, 24'h0);
    check_bit("abort_in_ready", in_ready, 1'b1);
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    check_bit("abort_no_valid", ok, 1'b0);
    do_vec("after_abort", pack3(9, -14, 0), 0);

    // Back-to-back vectors with both handshakes held high.
    tp_exp[0] = pack3(3, 0, 2);
    tp_exp[1] = pack3(8, 7, 3);
    tp_exp[2] = pack3(6, 0, 10);
    base_a = acc_cyc_q.size();
    base_g = got_q.size();
    set_vec(1, 2, 1, 1, 2, -1, 0, 1, 0, 0, 0, 2'd0);
    @(posedge clk); #1;
    in_valid  = 1;
    out_ready = 1;
    for (int v = 0; v < 3; v++) begin
      ok = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; break; end
      end
      check_bit("tp_accept", ok, 1'b1);
      @(posedge clk); #1;
      if (v == 0) set_vec(5, 3, 1, 1, 2, -1, 0, 1, 0, 0, 0, 2'd0);
      else if (v == 1) set_vec(-4, 10, 1, 1, 2, -1, 0, 1, 0, 0, 0, 2'd1);
      else in_valid = 0;
    end
    for (int k = 0; k < 40 && got_q.size() < base_g + 3; k++) @(negedge clk);
    check_int("tp_results", got_q.size() - base_g, 3);
    check_int("tp_accepts", acc_cyc_q.size() - base_a, 3);
    if (acc_cyc_q.size() >= base_a + 3) begin
      check_int("tp_gap01", acc_cyc_q[base_a+1] - acc_cyc_q[base_a], 8);
      check_int("tp_gap12", acc_cyc_q[base_a+2] - acc_cyc_q[base_a+1], 8);
    end
    for (int v = 0; v < 3; v++) begin
      if (got_q.size() > base_g + v) check_vec("tp_order", got_q[base_g+v], tp_exp[v]);
    end
    @(posedge clk); #1;
    out_ready = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
